// File: rtl/odd_sequence_checker.sv
// Lock-and-track checker for the odd-counter stream 0/1,3,5,7,9,11,1,...
// Optional saturating violation counter: define ODD_CHK_ERRCNT_EN.
module odd_sequence_checker #(
    parameter int LAP_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [3:0]       value_in,
    output logic             locked,
    output logic             seq_error,
    output logic [3:0]       err_value,
    output logic             marker,
    output logic [3:0]       expected,
    output logic [LAP_W-1:0] lap_count
`ifdef ODD_CHK_ERRCNT_EN
    ,
    output logic [7:0]       error_count
`endif
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       expected_reg, expected_next;
    logic [3:0]       err_value_reg, err_value_next;
    logic [LAP_W-1:0] lap_count_reg, lap_count_next;
    logic             locked_reg, locked_next;
    logic             seq_error_reg, seq_error_next;
    logic             marker_reg, marker_next;
    logic             accept;

    // Successor table; an entry with legal_tbl low has no successor.
    logic [3:0] succ_tbl  [16];
    logic       legal_tbl [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_succ
            if (gi == 0 || gi == 11) begin : g_to_one
                assign succ_tbl[gi]  = 4'd1;
                assign legal_tbl[gi] = 1'b1;
            end else if ((gi % 2) == 1 && gi < 11) begin : g_odd
                assign succ_tbl[gi]  = 4'(gi + 2);
                assign legal_tbl[gi] = 1'b1;
            end else begin : g_illegal
                assign succ_tbl[gi]  = 4'd0;
                assign legal_tbl[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        expected_next  = expected_reg;
        err_value_next = err_value_reg;
        lap_count_next = lap_count_reg;
        seq_error_next = 1'b0;
        marker_next    = 1'b0;
        accept         = 1'b0;

        if (valid_in) begin
            case (state_reg)
                HUNT: begin
                    if (legal_tbl[value_in]) begin
                        state_next    = VERIFY;
                        expected_next = succ_tbl[value_in];
                    end
                end
                VERIFY: begin
                    if (value_in == expected_reg) begin
                        state_next    = LOCKED;
                        expected_next = succ_tbl[value_in];
                        accept        = 1'b1;
                    end else begin
                        state_next    = HUNT;
                        expected_next = 4'd0;
                    end
                end
                LOCKED: begin
                    // expected is never 0 here, so a stray 0 is always a violation
                    if (value_in == expected_reg) begin
                        expected_next = succ_tbl[value_in];
                        accept        = 1'b1;
                    end else begin
                        state_next     = HUNT;
                        expected_next  = 4'd0;
                        seq_error_next = 1'b1;
                        err_value_next = value_in;
                    end
                end
                default: begin
                    state_next    = HUNT;
                    expected_next = 4'd0;
                end
            endcase
        end

        if (accept) begin
            marker_next = (value_in == 4'd3);
            if (value_in == 4'd11) begin
                lap_count_next = lap_count_reg + 1'b1;
            end
        end

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= HUNT;
            expected_reg  <= 4'd0;
            err_value_reg <= 4'd0;
            lap_count_reg <= '0;
            locked_reg    <= 1'b0;
            seq_error_reg <= 1'b0;
            marker_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            expected_reg  <= expected_next;
            err_value_reg <= err_value_next;
            lap_count_reg <= lap_count_next;
            locked_reg    <= locked_next;
            seq_error_reg <= seq_error_next;
            marker_reg    <= marker_next;
        end
    end

`ifdef ODD_CHK_ERRCNT_EN
    logic [7:0] error_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            error_count_reg <= 8'd0;
        end else if (seq_error_next && error_count_reg != 8'hFF) begin
            error_count_reg <= error_count_reg + 8'd1;
        end
    end

    assign error_count = error_count_reg;
`endif

    assign locked    = locked_reg;
    assign seq_error = seq_error_reg;
    assign err_value = err_value_reg;
    assign marker    = marker_reg;
    assign expected  = expected_reg;
    assign lap_count = lap_count_reg;

endmodule
